// File: rtl/precise_trap_controller_pkg.sv
// trap_pkg: shared state encoding, cause codes and ROB age helper for the trap controller.
package trap_pkg;
  typedef enum logic [1:0] {IDLE, PENDING, FLUSH, REDIRECT} state_t;
  localparam int unsigned CAUSE_ILLEGAL       = 2;
  localparam int unsigned CAUSE_BREAKPOINT    = 3;
  localparam int unsigned CAUSE_LOAD_MISALIGN = 4;
  localparam int unsigned CAUSE_ECALL         = 11;
  function automatic logic [15:0] rob_age(logic [15:0] idx, logic [15:0] head, logic [15:0] mask);
    return (idx - head) & mask;
  endfunction
endpackage

// File: rtl/trap_vector_gen.sv
// trap_vector_gen: direct or vectored trap target from cause and base.
module trap_vector_gen #(
  parameter int PC_W    = 32,
  parameter int CAUSE_W = 4
) (
  input  logic [CAUSE_W-1:0] cause,
  input  logic [PC_W-1:0]    base,
  input  logic               mode,
  output logic [PC_W-1:0]    target
);
  assign target = mode ? base + (PC_W'(cause) << 2) : base;
endmodule

// File: rtl/precise_trap_controller.sv
// precise_trap_controller: oldest-exception tracking, retire gating, flush sequencing and trap/mret redirect.
module precise_trap_controller
  import trap_pkg::*;
#(
  parameter int              ROB_DEPTH = 16,
  parameter int              PC_W      = 32,
  parameter int              CAUSE_W   = 4,
  parameter int              FLUSH_CYC = 2,
  parameter logic [PC_W-1:0] TVEC_BASE = 32'h0000_0100,
  parameter bit              VECTORED  = 1'b0,
  localparam int             IDX_W     = $clog2(ROB_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               exc_valid,
  input  logic [IDX_W-1:0]   exc_rob_idx,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic [PC_W-1:0]    exc_pc,
  input  logic [IDX_W-1:0]   rob_head,
  input  logic               commit_valid,
  input  logic               mret,
  output logic               retire_en,
  output logic               flush,
  output logic               redirect_valid,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    mepc,
  output logic [CAUSE_W-1:0] mcause,
  output logic               busy
);
  localparam int CNT_W = $clog2(FLUSH_CYC + 1);
  localparam logic [15:0] AGE_MASK = 16'(ROB_DEPTH - 1);
  state_t state, state_n;
  logic [IDX_W-1:0] pend_idx;
  logic [CAUSE_W-1:0] pend_cause;
  logic [PC_W-1:0] pend_pc, vec_pc;
  logic [CNT_W-1:0] cnt;
  logic is_mret, take, older, head_hit;
  trap_vector_gen #(.PC_W(PC_W), .CAUSE_W(CAUSE_W)) u_vec (
    .cause(mcause), .base(TVEC_BASE), .mode(VECTORED), .target(vec_pc)
  );
  assign head_hit = commit_valid & (rob_head == pend_idx);
  assign older = (rob_age(16'(exc_rob_idx), 16'(rob_head), AGE_MASK) <
                  rob_age(16'(pend_idx), 16'(rob_head), AGE_MASK)) |
                 ((exc_rob_idx == pend_idx) & (exc_cause < pend_cause));
  // An exception reported against the head blocks its retirement before it is even latched.
  assign retire_en = reset & commit_valid & (state == IDLE | state == PENDING) &
                     ~(state == PENDING & rob_head == pend_idx) &
                     ~(exc_valid & exc_rob_idx == rob_head);
  always_comb begin
    state_n = state;
    take    = 1'b0;
    case (state)
      IDLE: begin
        take    = exc_valid;
        state_n = exc_valid ? PENDING : mret ? FLUSH : IDLE;
      end
      PENDING: begin
        take    = exc_valid & older;
        state_n = head_hit ? FLUSH : PENDING;
      end
      FLUSH:    state_n = (cnt == CNT_W'(FLUSH_CYC - 1)) ? REDIRECT : FLUSH;
      REDIRECT: state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      pend_idx       <= '0;
      pend_cause     <= '0;
      pend_pc        <= '0;
      cnt            <= '0;
      is_mret        <= 1'b0;
      mepc           <= '0;
      mcause         <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b0;
    end else begin
      state <= state_n;
      if (take) begin
        pend_idx   <= exc_rob_idx;
        pend_cause <= exc_cause;
        pend_pc    <= exc_pc;
      end
      if (state == PENDING && state_n == FLUSH) begin
        mepc    <= pend_pc;
        mcause  <= pend_cause;
        is_mret <= 1'b0;
      end
      if (state == IDLE && state_n == FLUSH) is_mret <= 1'b1;
      cnt            <= (state == FLUSH) ? cnt + 1'b1 : '0;
      flush          <= state_n == FLUSH;
      redirect_valid <= state_n == REDIRECT;
      redirect_pc    <= (state_n == REDIRECT) ? (is_mret ? mepc : vec_pc) : '0;
      busy           <= state_n != IDLE;
    end
  end
endmodule
